// File: rtl/vcache_stat_snapshot_pkg.sv
// Shared types and helpers for the vcache statistics snapshot block.
package vcache_stat_snapshot_pkg;

  localparam int unsigned num_events_gp = 5;
  localparam int unsigned gctr_width_gp = 32;

  typedef enum logic [2:0] {
    e_ld      = 3'd0,
    e_st      = 3'd1,
    e_atomic  = 3'd2,
    e_ld_miss = 3'd3,
    e_st_miss = 3'd4
  } event_e;

  typedef enum logic {
    s_idle  = 1'b0,
    s_drain = 1'b1
  } snap_state_e;

  // A single bank still needs a 1-bit index so record fields never collapse to zero width.
  function automatic int unsigned bank_width(input int unsigned num_banks);
    return (num_banks > 1) ? $clog2(num_banks) : 1;
  endfunction

endpackage

// File: rtl/vcache_stat_snapshot_if.sv
// Snapshot request and record stream handshake between the profiler and its host/logger.
interface vcache_stat_snapshot_if
  import vcache_stat_snapshot_pkg::*;
#(
  parameter int unsigned num_banks_p = 8,
  parameter int unsigned ctr_width_p = 32,
  parameter int unsigned tag_width_p = 32
);

  localparam int unsigned bank_width_lp = bank_width(num_banks_p);

  logic                     snap_v_i;
  logic [tag_width_p-1:0]   snap_tag_i;
  logic                     snap_ready_o;

  logic                     rec_v_o;
  logic [bank_width_lp-1:0] rec_bank_o;
  event_e                   rec_event_o;
  logic [ctr_width_p-1:0]   rec_count_o;
  logic [tag_width_p-1:0]   rec_tag_o;
  logic [gctr_width_gp-1:0] rec_gctr_o;
  logic                     rec_yumi_i;

  modport master (
    input  snap_v_i, snap_tag_i, rec_yumi_i,
    output snap_ready_o, rec_v_o, rec_bank_o, rec_event_o, rec_count_o, rec_tag_o, rec_gctr_o
  );

  modport slave (
    output snap_v_i, snap_tag_i, rec_yumi_i,
    input  snap_ready_o, rec_v_o, rec_bank_o, rec_event_o, rec_count_o, rec_tag_o, rec_gctr_o
  );

endinterface

// File: rtl/vcache_stat_snapshot_sat_counter.sv
// Saturating event counter: holds at all-ones, clear beats a same-cycle increment.
module vcache_stat_snapshot_sat_counter #(
  parameter int unsigned width_p = 32
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               inc_i,
  output logic [width_p-1:0] count_o
);

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      count_o <= '0;
    end else if (inc_i && !(&count_o)) begin
      count_o <= count_o + width_p'(1);
    end
  end

endmodule

// File: rtl/vcache_stat_snapshot.sv
// Multi-bank vcache event profiler: live saturating counters, snapshot into shadow
// registers, then drain the shadow as a valid/yumi record stream.
module vcache_stat_snapshot
  import vcache_stat_snapshot_pkg::*;
#(
  parameter int unsigned num_banks_p = 8,
  parameter int unsigned ctr_width_p = 32,
  parameter int unsigned tag_width_p = 32
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [num_banks_p-1:0]   v_i,
  input  logic [num_banks_p-1:0]   yumi_i,
  input  logic [num_banks_p-1:0]   ld_op_i,
  input  logic [num_banks_p-1:0]   st_op_i,
  input  logic [num_banks_p-1:0]   atomic_op_i,
  input  logic [num_banks_p-1:0]   miss_i,
  input  logic                     clear_i,
  input  logic [gctr_width_gp-1:0] global_ctr_i,
  vcache_stat_snapshot_if.master   bus
);

  localparam int unsigned bank_width_lp = bank_width(num_banks_p);
  localparam logic [bank_width_lp-1:0] last_bank_lp = bank_width_lp'(num_banks_p - 1);

  logic [num_events_gp-1:0] inc    [num_banks_p];
  logic [ctr_width_p-1:0]   live   [num_banks_p][num_events_gp];
  logic [ctr_width_p-1:0]   shadow [num_banks_p][num_events_gp];
  logic [tag_width_p-1:0]   tag_q;
  logic [gctr_width_gp-1:0] gctr_q;

  snap_state_e              state_q, state_n;
  logic [bank_width_lp-1:0] bank_q, bank_n;
  event_e                   evt_q, evt_n;
  logic                     snap_accept;

  // Per-bank event decode and counter array; bit order follows event_e.
  for (genvar b = 0; b < num_banks_p; b++) begin : g_bank
    logic fire;
    assign fire   = v_i[b] & yumi_i[b];
    assign inc[b] = {fire & st_op_i[b] & miss_i[b],
                     fire & ld_op_i[b] & miss_i[b],
                     fire & atomic_op_i[b],
                     fire & st_op_i[b],
                     fire & ld_op_i[b]};

    for (genvar e = 0; e < num_events_gp; e++) begin : g_evt
      vcache_stat_snapshot_sat_counter #(
        .width_p (ctr_width_p)
      ) u_ctr (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (clear_i),
        .inc_i   (inc[b][e]),
        .count_o (live[b][e])
      );
    end
  end

  // Shadow captures register values, so same-cycle increments/clears land only in live.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int b = 0; b < num_banks_p; b++) begin
        for (int e = 0; e < num_events_gp; e++) begin
          shadow[b][e] <= '0;
        end
      end
      tag_q  <= '0;
      gctr_q <= '0;
    end else if (snap_accept) begin
      shadow <= live;
      tag_q  <= bus.snap_tag_i;
      gctr_q <= global_ctr_i;
    end
  end

  // State and record index registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= s_idle;
      bank_q  <= '0;
      evt_q   <= e_ld;
    end else begin
      state_q <= state_n;
      bank_q  <= bank_n;
      evt_q   <= evt_n;
    end
  end

  // Next-state and handshake outputs; requests seen during DRAIN are dropped.
  always_comb begin
    state_n          = state_q;
    bank_n           = bank_q;
    evt_n            = evt_q;
    snap_accept      = 1'b0;
    bus.snap_ready_o = 1'b0;
    bus.rec_v_o      = 1'b0;

    case (state_q)
      s_idle: begin
        bus.snap_ready_o = 1'b1;
        if (bus.snap_v_i) begin
          snap_accept = 1'b1;
          bank_n      = '0;
          evt_n       = e_ld;
          state_n     = s_drain;
        end
      end
      s_drain: begin
        bus.rec_v_o = 1'b1;
        if (bus.rec_yumi_i) begin
          if (evt_q == e_st_miss) begin
            evt_n = e_ld;
            if (bank_q == last_bank_lp) begin
              state_n = s_idle;
            end else begin
              bank_n = bank_q + bank_width_lp'(1);
            end
          end else begin
            evt_n = event_e'(evt_q + 3'd1);
          end
        end
      end
      default: state_n = s_idle;
    endcase
  end

  // Record fields come straight off registers and stay stable until yumi.
  assign bus.rec_bank_o  = bank_q;
  assign bus.rec_event_o = evt_q;
  assign bus.rec_count_o = shadow[bank_q][evt_q];
  assign bus.rec_tag_o   = tag_q;
  assign bus.rec_gctr_o  = gctr_q;

endmodule

// File: tb/tb_vcache_stat_snapshot.sv
// Directed bench for vcache_stat_snapshot: 4 banks, 4-bit counters, 8-bit tags.
module tb_vcache_stat_snapshot;
  import vcache_stat_snapshot_pkg::*;

  localparam int unsigned NB = 4;
  localparam int unsigned CW = 4;
  localparam int unsigned TW = 8;
  localparam int NREC = 5 * NB;

  logic          clk = 1'b0;
  logic          reset_i;
  logic [NB-1:0] v_i, yumi_i, ld_op_i, st_op_i, atomic_op_i, miss_i;
  logic          clear_i;
  logic [31:0]   global_ctr_i;

  int checks = 0;
  int failures = 0;
  int exp_cnt [NB][5];

  vcache_stat_snapshot_if #(.num_banks_p(NB), .ctr_width_p(CW), .tag_width_p(TW)) bus ();

  vcache_stat_snapshot #(.num_banks_p(NB), .ctr_width_p(CW), .tag_width_p(TW)) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .v_i          (v_i),
    .yumi_i       (yumi_i),
    .ld_op_i      (ld_op_i),
    .st_op_i      (st_op_i),
    .atomic_op_i  (atomic_op_i),
    .miss_i       (miss_i),
    .clear_i      (clear_i),
    .global_ctr_i (global_ctr_i),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_exp();
    for (int b = 0; b < NB; b++)
      for (int e = 0; e < 5; e++)
        exp_cnt[b][e] = 0;
  endtask

  // One bank handshake with the given decode/miss bits for a single cycle.
  task automatic bank_op(input int b, input bit ld, input bit st, input bit at, input bit ms);
    v_i[b] = 1'b1; yumi_i[b] = 1'b1;
    ld_op_i[b] = ld; st_op_i[b] = st; atomic_op_i[b] = at; miss_i[b] = ms;
    step();
    v_i = '0; yumi_i = '0; ld_op_i = '0; st_op_i = '0; atomic_op_i = '0; miss_i = '0;
  endtask

  task automatic snap(input logic [7:0] tag, input logic [31:0] gc);
    chk("snap_ready_idle", 64'(bus.snap_ready_o), 64'(1));
    bus.snap_tag_i = tag;
    global_ctr_i = gc;
    bus.snap_v_i = 1'b1;
    step();
    bus.snap_v_i = 1'b0;
    chk("rec_v_after_accept", 64'(bus.rec_v_o), 64'(1));
    chk("snap_ready_drain", 64'(bus.snap_ready_o), 64'(0));
  endtask

  task automatic drain(input int n, input logic [7:0] tag, input logic [31:0] gc, input bit hold);
    for (int i = 0; i < n; i++) begin
      int b;
      int e;
      b = i / 5;
      e = i % 5;
      chk("rec_v", 64'(bus.rec_v_o), 64'(1));
      chk("rec_bank", 64'(bus.rec_bank_o), 64'(b));
      chk("rec_event", 64'(bus.rec_event_o), 64'(e));
      chk("rec_count", 64'(bus.rec_count_o), 64'(exp_cnt[b][e]));
      chk("rec_tag", 64'(bus.rec_tag_o), 64'(tag));
      chk("rec_gctr", 64'(bus.rec_gctr_o), 64'(gc));
      if (hold && i == 0) begin
        bus.snap_tag_i = 8'hEE;
        global_ctr_i = 32'd999;
        bus.snap_v_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
          chk("snap_ready_hold", 64'(bus.snap_ready_o), 64'(0));
          step();
          bus.snap_v_i = 1'b0;
          chk("hold_rec_v", 64'(bus.rec_v_o), 64'(1));
          chk("hold_bank", 64'(bus.rec_bank_o), 64'(0));
          chk("hold_event", 64'(bus.rec_event_o), 64'(0));
          chk("hold_count", 64'(bus.rec_count_o), 64'(exp_cnt[0][0]));
          chk("hold_tag", 64'(bus.rec_tag_o), 64'(tag));
          chk("hold_gctr", 64'(bus.rec_gctr_o), 64'(gc));
        end
      end
      bus.rec_yumi_i = 1'b1;
      step();
      bus.rec_yumi_i = 1'b0;
    end
    if (n == NREC) begin
      chk("rec_v_done", 64'(bus.rec_v_o), 64'(0));
      chk("snap_ready_done", 64'(bus.snap_ready_o), 64'(1));
    end
  endtask

  initial begin
    reset_i = 1'b1; clear_i = 1'b0; global_ctr_i = '0;
    v_i = '0; yumi_i = '0; ld_op_i = '0; st_op_i = '0; atomic_op_i = '0; miss_i = '0;
    bus.snap_v_i = 1'b0; bus.snap_tag_i = '0; bus.rec_yumi_i = 1'b0;
    #1;
    step(); step();
    reset_i = 1'b0;
    chk("reset_snap_ready", 64'(bus.snap_ready_o), 64'(1));
    chk("reset_rec_v", 64'(bus.rec_v_o), 64'(0));

    // Loads/stores with misses on banks 0 and 1.
    bank_op(0, 1, 0, 0, 1); bank_op(0, 1, 0, 0, 0);
    bank_op(0, 1, 0, 0, 1); bank_op(0, 1, 0, 0, 0);
    bank_op(1, 0, 1, 0, 0); bank_op(1, 0, 1, 0, 1); bank_op(1, 0, 1, 0, 0);
    clear_exp();
    exp_cnt[0][0] = 4; exp_cnt[0][3] = 2; exp_cnt[1][1] = 3; exp_cnt[1][4] = 1;
    snap(8'hA5, 32'd100);
    drain(NREC, 8'hA5, 32'd100, 1'b0);

    // Bank 2 loads saturate a 4-bit counter.
    for (int i = 0; i < 20; i++) bank_op(2, 1, 0, 0, 0);
    exp_cnt[2][0] = 15;
    snap(8'h3C, 32'd200);
    drain(NREC, 8'h3C, 32'd200, 1'b0);

    // Snapshot takes pre-increment value; dropped request and stalled record during drain.
    bank_op(0, 1, 0, 0, 0);
    v_i[0] = 1'b1; yumi_i[0] = 1'b1; ld_op_i[0] = 1'b1;
    exp_cnt[0][0] = 5;
    snap(8'h5A, 32'd250);
    v_i = '0; yumi_i = '0; ld_op_i = '0;
    drain(NREC, 8'h5A, 32'd250, 1'b1);
    exp_cnt[0][0] = 6;
    snap(8'h11, 32'd300);
    drain(NREC, 8'h11, 32'd300, 1'b0);

    // Clear in the snapshot cycle: shadow keeps old values, live goes to zero.
    bank_op(0, 1, 0, 0, 0);
    exp_cnt[0][0] = 7;
    clear_i = 1'b1;
    snap(8'h22, 32'd350);
    clear_i = 1'b0;
    drain(NREC, 8'h22, 32'd350, 1'b0);
    bank_op(3, 0, 0, 1, 0);
    clear_exp();
    exp_cnt[3][2] = 1;
    snap(8'h77, 32'd400);
    drain(NREC, 8'h77, 32'd400, 1'b0);

    // Reset mid-drain aborts the stream and zeroes everything.
    snap(8'h99, 32'd500);
    drain(3, 8'h99, 32'd500, 1'b0);
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    chk("abort_rec_v", 64'(bus.rec_v_o), 64'(0));
    chk("abort_snap_ready", 64'(bus.snap_ready_o), 64'(1));
    clear_exp();
    snap(8'h42, 32'd600);
    drain(NREC, 8'h42, 32'd600, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
